// File: rtl/decode_exec_pipe.sv
// ---------------------------------------------------------------------------
// decode_exec_pipe
//   Decode-to-memory slice of a 5-stage MIPS-style pipeline. The D-stage
//   instruction is split into fields (opcode/funct go combinationally to the
//   controller), operands and controls are carried through an ID/EX register,
//   the EX stage runs the ALU and branch adder, and the results are captured
//   in an EX/MEM register for the memory stage.
//
// Parameters
//   DATA_W  datapath / operand width
//   ADDR_W  PC and branch-target width
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   en              pipeline advance; 0 holds both register stages
//   instr_d         D-stage instruction
//   pc_plus1_d      D-stage PC+1
//   rd1_d, rd2_d    register-file read data (rs, rt)
//   alu_ctrl_d      ALU operation
//   alu_src_b_d     1 = ALU B is sign-extended immediate, 0 = rd2
//   reg_dst_d       1 = destination is rd, 0 = rt
//   opcode_d, funct_d, rs_d, rt_d, jump_d   combinational decode fields
//   alu_out_m, zero_m, write_data_m, write_reg_m, pc_branch_m   EX/MEM outputs
//   overflow_m      signed add/sub overflow (only with ALU_OVERFLOW_EN)
//
// Build option
//   ALU_OVERFLOW_EN  adds the registered overflow_m output
// ---------------------------------------------------------------------------
module decode_exec_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [31:0]       instr_d,
    input  logic [ADDR_W-1:0] pc_plus1_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [2:0]        alu_ctrl_d,
    input  logic              alu_src_b_d,
    input  logic              reg_dst_d,
    output logic [5:0]        opcode_d,
    output logic [5:0]        funct_d,
    output logic [4:0]        rs_d,
    output logic [4:0]        rt_d,
    output logic [25:0]       jump_d,
    output logic [DATA_W-1:0] alu_out_m,
    output logic              zero_m,
    output logic [DATA_W-1:0] write_data_m,
    output logic [4:0]        write_reg_m,
    output logic [ADDR_W-1:0] pc_branch_m
`ifdef ALU_OVERFLOW_EN
    ,
    output logic              overflow_m
`endif
);

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ZERO = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_t;

    // ---------------- D stage: field decode ----------------
    logic [4:0]        rd_d;
    logic [31:0]       sign_imm32_d;
    logic [DATA_W-1:0] sign_imm_d;

    assign opcode_d     = instr_d[31:26];
    assign rs_d         = instr_d[25:21];
    assign rt_d         = instr_d[20:16];
    assign rd_d         = instr_d[15:11];
    assign funct_d      = instr_d[5:0];
    assign jump_d       = instr_d[25:0];
    assign sign_imm32_d = {{16{instr_d[15]}}, instr_d[15:0]};
    // 32-bit sign-extended value, then zero-extended or truncated to DATA_W
    assign sign_imm_d   = DATA_W'(sign_imm32_d);

    // ---------------- ID/EX register ----------------
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_sign_imm;
    logic [ADDR_W-1:0] ex_pc_plus1;
    logic [2:0]        ex_alu_ctrl;
    logic              ex_alu_src_b;
    logic              ex_reg_dst;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_sign_imm  <= '0;
            ex_pc_plus1  <= '0;
            ex_alu_ctrl  <= '0;
            ex_alu_src_b <= 1'b0;
            ex_reg_dst   <= 1'b0;
        end else if (en) begin
            ex_rd1       <= rd1_d;
            ex_rd2       <= rd2_d;
            ex_rt        <= rt_d;
            ex_rd        <= rd_d;
            ex_sign_imm  <= sign_imm_d;
            ex_pc_plus1  <= pc_plus1_d;
            ex_alu_ctrl  <= alu_ctrl_d;
            ex_alu_src_b <= alu_src_b_d;
            ex_reg_dst   <= reg_dst_d;
        end
    end

    // ---------------- EX stage ----------------
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] sum_e;
    logic [DATA_W-1:0] diff_e;
    logic [DATA_W-1:0] alu_result_e;
    logic              zero_e;
    logic [4:0]        write_reg_e;
    logic [ADDR_W-1:0] pc_branch_e;
    alu_op_t           alu_op_e;

    assign alu_a       = ex_rd1;
    assign alu_b       = ex_alu_src_b ? ex_sign_imm : ex_rd2;
    assign sum_e       = alu_a + alu_b;
    assign diff_e      = alu_a - alu_b;
    assign write_reg_e = ex_reg_dst ? ex_rd : ex_rt;
    assign pc_branch_e = ex_pc_plus1 + ex_sign_imm[ADDR_W-1:0];
    assign alu_op_e    = alu_op_t'(ex_alu_ctrl);

    always_comb begin
        alu_result_e = '0;
        case (alu_op_e)
            ALU_AND:  alu_result_e = alu_a & alu_b;
            ALU_OR:   alu_result_e = alu_a | alu_b;
            ALU_ADD:  alu_result_e = sum_e;
            ALU_ZERO: alu_result_e = '0;
            ALU_ANDN: alu_result_e = alu_a & ~alu_b;
            ALU_ORN:  alu_result_e = alu_a | ~alu_b;
            ALU_SUB:  alu_result_e = diff_e;
            ALU_SLT:  alu_result_e = DATA_W'($signed(alu_a) < $signed(alu_b));
            default:  alu_result_e = '0;
        endcase
    end

    assign zero_e = (alu_result_e == '0);

`ifdef ALU_OVERFLOW_EN
    logic overflow_e;

    // Signed overflow: add with like-signed operands, or subtract with
    // unlike-signed operands, producing a result whose sign differs from A.
    always_comb begin
        overflow_e = 1'b0;
        case (alu_op_e)
            ALU_ADD: overflow_e = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                                  (sum_e[DATA_W-1] != alu_a[DATA_W-1]);
            ALU_SUB: overflow_e = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                                  (diff_e[DATA_W-1] != alu_a[DATA_W-1]);
            default: overflow_e = 1'b0;
        endcase
    end
`endif

    // ---------------- EX/MEM register ----------------
    // zero_m is stored as 0 on reset rather than recomputed from the cleared
    // ALU result, so it only reads 1 after the first enabled edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_m    <= '0;
            zero_m       <= 1'b0;
            write_data_m <= '0;
            write_reg_m  <= '0;
            pc_branch_m  <= '0;
`ifdef ALU_OVERFLOW_EN
            overflow_m   <= 1'b0;
`endif
        end else if (en) begin
            alu_out_m    <= alu_result_e;
            zero_m       <= zero_e;
            write_data_m <= ex_rd2;
            write_reg_m  <= write_reg_e;
            pc_branch_m  <= pc_branch_e;
`ifdef ALU_OVERFLOW_EN
            overflow_m   <= overflow_e;
`endif
        end
    end

endmodule

// File: tb/tb_decode_exec_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_exec_pipe
//   Scoreboard bench for decode_exec_pipe. Each issued instruction pushes its
//   hand-computed EX/MEM result into a queue; a monitor pops and compares
//   whenever a tracked instruction reaches the outputs, and checks that the
//   outputs hold their last value while the pipeline is stalled.
// ---------------------------------------------------------------------------
module tb_decode_exec_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] instr_d;
    logic [5:0]  pc_plus1_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [2:0]  alu_ctrl_d;
    logic        alu_src_b_d;
    logic        reg_dst_d;
    logic [5:0]  opcode_d;
    logic [5:0]  funct_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [25:0] jump_d;
    logic [31:0] alu_out_m;
    logic        zero_m;
    logic [31:0] write_data_m;
    logic [4:0]  write_reg_m;
    logic [5:0]  pc_branch_m;
`ifdef ALU_OVERFLOW_EN
    logic        overflow_m;
`endif

    decode_exec_pipe #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .instr_d      (instr_d),
        .pc_plus1_d   (pc_plus1_d),
        .rd1_d        (rd1_d),
        .rd2_d        (rd2_d),
        .alu_ctrl_d   (alu_ctrl_d),
        .alu_src_b_d  (alu_src_b_d),
        .reg_dst_d    (reg_dst_d),
        .opcode_d     (opcode_d),
        .funct_d      (funct_d),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .jump_d       (jump_d),
        .alu_out_m    (alu_out_m),
        .zero_m       (zero_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m),
        .pc_branch_m  (pc_branch_m)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow_m   (overflow_m)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wd;
        logic [4:0]  wreg;
        logic [5:0]  pcb;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   have_last = 0;
    int   total = 0;
    int   bad = 0;

    // Bench-side occupancy tracking: which pipeline slot holds something the
    // scoreboard expects. Reset leaves an all-zero bubble in ID/EX.
    logic issue_v = 1'b0;
    logic v_ex = 1'b0;
    logic fresh = 1'b0;
    logic hold = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            v_ex  <= 1'b1;
            fresh <= 1'b0;
            hold  <= 1'b0;
        end else if (en) begin
            v_ex  <= issue_v;
            fresh <= v_ex;
            hold  <= 1'b0;
        end else begin
            fresh <= 1'b0;
            hold  <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk($sformatf("%s%0d_alu_out", tag, e.id), alu_out_m, e.alu);
        chk($sformatf("%s%0d_zero", tag, e.id), 32'(zero_m), 32'(e.zero));
        chk($sformatf("%s%0d_write_data", tag, e.id), write_data_m, e.wd);
        chk($sformatf("%s%0d_write_reg", tag, e.id), 32'(write_reg_m), 32'(e.wreg));
        chk($sformatf("%s%0d_pc_branch", tag, e.id), 32'(pc_branch_m), 32'(e.pcb));
`ifdef ALU_OVERFLOW_EN
        chk($sformatf("%s%0d_overflow", tag, e.id), 32'(overflow_m), 32'(e.ovf));
`endif
    endtask

    function automatic exp_t mk(input int id, input logic [31:0] alu, input logic zero,
                                input logic [31:0] wd, input logic [4:0] wreg,
                                input logic [5:0] pcb, input logic ovf);
        exp_t e;
        e.id = id; e.alu = alu; e.zero = zero; e.wd = wd;
        e.wreg = wreg; e.pcb = pcb; e.ovf = ovf;
        return e;
    endfunction

    // Monitor: compares one scoreboard entry per tracked output, and the
    // held value on every stalled edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                have_last = 0;
            end else if (fresh) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got alu_out %h, want no output", alu_out_m);
                end else begin
                    e = exp_q.pop_front();
                    check_out("v", e);
                    last_exp  = e;
                    have_last = 1;
                end
            end else if (hold && have_last) begin
                check_out("hold_v", last_exp);
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [5:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input logic srcb, input logic rdst,
                         input exp_t e);
        @(negedge clk);
        instr_d     = instr;
        pc_plus1_d  = pc;
        rd1_d       = a;
        rd2_d       = b;
        alu_ctrl_d  = ctrl;
        alu_src_b_d = srcb;
        reg_dst_d   = rdst;
        en          = 1'b1;
        issue_v     = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_out"}, alu_out_m, 32'h0);
        chk({tag, "_zero"}, 32'(zero_m), 32'h0);
        chk({tag, "_write_data"}, write_data_m, 32'h0);
        chk({tag, "_write_reg"}, 32'(write_reg_m), 32'h0);
        chk({tag, "_pc_branch"}, 32'(pc_branch_m), 32'h0);
`ifdef ALU_OVERFLOW_EN
        chk({tag, "_overflow"}, 32'(overflow_m), 32'h0);
`endif
    endtask

    // Hold reset for n edges, check cleared outputs, drop anything in flight,
    // and expect the reset bubble (AND of zeros -> zero_m=1) first.
    task automatic do_reset(input int n, input string tag);
        @(negedge clk);
        reset   = 1'b1;
        issue_v = 1'b0;
        repeat (n) @(negedge clk);
        check_reset_outputs(tag);
        exp_q.delete();
        exp_q.push_back(mk(0, 32'h0, 1'b1, 32'h0, 5'd0, 6'd0, 1'b0));
        reset = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b1;
        instr_d = '0; pc_plus1_d = '0; rd1_d = '0; rd2_d = '0;
        alu_ctrl_d = '0; alu_src_b_d = 1'b0; reg_dst_d = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        exp_q.push_back(mk(0, 32'h0, 1'b1, 32'h0, 5'd0, 6'd0, 1'b0));
        reset = 1'b0;

        // addi $2, $0, -1 with rd1=5 -> 4; branch 10+63 wraps to 9
        issue(32'h2002_FFFF, 6'd10, 32'd5, 32'h0000_1234, 3'b010, 1'b1, 1'b0,
              mk(1, 32'd4, 1'b0, 32'h0000_1234, 5'd2, 6'd9, 1'b0));
        #1;
        chk("decode_opcode", 32'(opcode_d), 32'h08);
        chk("decode_rs", 32'(rs_d), 32'h0);
        chk("decode_rt", 32'(rt_d), 32'h2);
        chk("decode_funct", 32'(funct_d), 32'h3F);
        chk("decode_jump", 32'(jump_d), 32'h002_FFFF);

        // sub 7-7 -> 0, zero; rd=7
        issue(32'h00E7_3822, 6'd1, 32'd7, 32'd7, 3'b110, 1'b0, 1'b1,
              mk(2, 32'd0, 1'b1, 32'd7, 5'd7, 6'd35, 1'b0));
        // slt -1 < 1 -> 1
        issue(32'h0000_002A, 6'd20, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0, 1'b1,
              mk(3, 32'd1, 1'b0, 32'd1, 5'd0, 6'd62, 1'b0));
        // beq branch 62+3 wraps to 1
        issue(32'h1000_0003, 6'd62, 32'd3, 32'd3, 3'b110, 1'b0, 1'b0,
              mk(4, 32'd0, 1'b1, 32'd3, 5'd0, 6'd1, 1'b0));
        // imm 0xFFFE: branch 5+62 wraps to 3; OR 0xF0|0x0F
        issue(32'h1085_FFFE, 6'd5, 32'h0000_00F0, 32'h0000_000F, 3'b001, 1'b0, 1'b0,
              mk(5, 32'h0000_00FF, 1'b0, 32'h0000_000F, 5'd5, 6'd3, 1'b0));
        // A & ~imm: 0xFF00FFFF & ~0xF0; store data is rd2 despite alu_src_b
        issue(32'h8C43_00F0, 6'd0, 32'hFF00_FFFF, 32'hDEAD_BEEF, 3'b100, 1'b1, 1'b0,
              mk(6, 32'hFF00_FF0F, 1'b0, 32'hDEAD_BEEF, 5'd3, 6'd48, 1'b0));

        // Stall three edges; decode keeps following instr_d
        @(negedge clk);
        en = 1'b0;
        issue_v = 1'b0;
        instr_d = 32'hFC00_0000;
        rd1_d = 32'h1111_1111;
        #1;
        chk("stall_decode_opcode", 32'(opcode_d), 32'h3F);
        repeat (2) @(negedge clk);

        // A | ~B with B all-ones -> 0
        issue(32'h0000_0000, 6'd7, 32'h0, 32'hFFFF_FFFF, 3'b101, 1'b0, 1'b1,
              mk(7, 32'h0, 1'b1, 32'hFFFF_FFFF, 5'd0, 6'd7, 1'b0));
        // op 011 -> 0; this one is in flight when reset hits and is discarded
        issue(32'h0062_2025, 6'd2, 32'h55, 32'hAA, 3'b011, 1'b0, 1'b1,
              mk(8, 32'h0, 1'b1, 32'hAA, 5'd4, 6'd39, 1'b0));
        do_reset(1, "midreset");

        // AND
        issue(32'h0000_0000, 6'd3, 32'h0000_0F0F, 32'h0000_00FF, 3'b000, 1'b0, 1'b0,
              mk(9, 32'h0000_000F, 1'b0, 32'h0000_00FF, 5'd0, 6'd3, 1'b0));
        // 0x7FFFFFFF + 1 wraps, signed overflow
        issue(32'h0000_0020, 6'd4, 32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0, 1'b1,
              mk(10, 32'h8000_0000, 1'b0, 32'd1, 5'd0, 6'd36, 1'b1));
        // 0x80000000 - 1, signed overflow
        issue(32'h0000_0022, 6'd4, 32'h8000_0000, 32'd1, 3'b110, 1'b0, 1'b1,
              mk(11, 32'h7FFF_FFFF, 1'b0, 32'd1, 5'd0, 6'd38, 1'b1));
        // slt 1 < -1 is false
        issue(32'h0000_002A, 6'd0, 32'd1, 32'hFFFF_FFFF, 3'b111, 1'b0, 1'b1,
              mk(12, 32'h0, 1'b1, 32'hFFFF_FFFF, 5'd0, 6'd42, 1'b0));

        @(negedge clk);
        issue_v = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
